// File: rtl/npu_hold_pkg.sv
// Shared types and constants for the NPU hold-register load sequencer.
// Defines the bank geometry, the sequencer states and the length-saturation rule.
package npu_hold_pkg;

    localparam int N     = 8;
    localparam int NREG  = 4;
    localparam int IDX_W = $clog2(NREG + 1);

    localparam logic [NREG-1:0] HOLD_ALL = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // A zero or oversized request means "load the whole bank".
    function automatic logic [IDX_W-1:0] sat_len(input logic [IDX_W-1:0] cfg);
        if (cfg == '0 || cfg > IDX_W'(NREG)) begin
            return IDX_W'(NREG);
        end
        return cfg;
    endfunction

endpackage

// File: rtl/hold_onehot_dec.sv
// Turns an enable plus register index into an active-low one-hot hold vector.
// With en low every register keeps its value.
module hold_onehot_dec #(
    parameter int NREG  = 4,
    parameter int IDX_W = 3
) (
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [NREG-1:0]  hold
);

    always_comb begin
        hold = '1;
        for (int k = 0; k < NREG; k++) begin
            if (en && idx == IDX_W'(k)) begin
                hold[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/npu_hold_ctrl.sv
// Load sequencer for the NPU operand hold-register bank: steers a byte stream
// into successive registers, then locks the bank until released.
module npu_hold_ctrl
    import npu_hold_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [IDX_W-1:0]    cfg_len_i,
    input  logic                abort_i,
    input  logic                release_i,
    input  logic                in_valid,
    input  logic signed [N-1:0] in_data,
    output logic                in_ready,
    output logic signed [N-1:0] reg_din,
    output logic [NREG-1:0]     reg_hold,
    output logic                busy,
    output logic                locked,
    output logic                done,
    output logic [IDX_W-1:0]    load_idx
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  load_idx_q, load_idx_d;
    logic signed [N-1:0] reg_din_q, reg_din_d;
    logic [NREG-1:0]   reg_hold_q, reg_hold_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              locked_q, locked_d;
    logic              done_q, done_d;
    logic              accept;
    logic [NREG-1:0]   hold_vec;

    // in_ready_q is only ever high in LOAD, so this is the LOAD handshake.
    assign accept = in_valid & in_ready_q;

    hold_onehot_dec #(
        .NREG  (NREG),
        .IDX_W (IDX_W)
    ) u_dec (
        .en   (accept),
        .idx  (load_idx_q),
        .hold (hold_vec)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        load_idx_d = load_idx_q;
        reg_din_d  = reg_din_q;
        reg_hold_d = hold_vec;
        done_d     = 1'b0;

        if (accept) begin
            reg_din_d  = in_data;
            load_idx_d = load_idx_q + IDX_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d      = sat_len(cfg_len_i);
                    load_idx_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                // Abort wins over completion; the byte in flight is still written.
                if (abort_i) begin
                    state_d    = IDLE;
                    load_idx_d = '0;
                end else if (accept && (load_idx_q + IDX_W'(1)) == len_q) begin
                    state_d = LOCKED;
                    done_d  = 1'b1;
                end
            end
            LOCKED: begin
                if (release_i) begin
                    state_d    = IDLE;
                    load_idx_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                load_idx_d = '0;
                reg_hold_d = HOLD_ALL;
            end
        endcase

        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
        locked_d   = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= IDX_W'(NREG);
            load_idx_q <= '0;
            reg_din_q  <= '0;
            reg_hold_q <= HOLD_ALL;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            locked_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            load_idx_q <= load_idx_d;
            reg_din_q  <= reg_din_d;
            reg_hold_q <= reg_hold_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            locked_q   <= locked_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign reg_din  = reg_din_q;
    assign reg_hold = reg_hold_q;
    assign busy     = busy_q;
    assign locked   = locked_q;
    assign done     = done_q;
    assign load_idx = load_idx_q;

endmodule

// File: tb/tb_npu_hold_ctrl.sv
// Self-checking bench for npu_hold_ctrl with a REG8_hold-style register bank
// attached, compared against a transaction-level reference model.
module tb_npu_hold_ctrl;
    import npu_hold_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start_i, abort_i, release_i, in_valid;
    logic [IDX_W-1:0] cfg_len_i, load_idx;
    logic [N-1:0]     in_data, reg_din;
    logic [NREG-1:0]  reg_hold;
    logic             in_ready, busy, locked, done;

    // REG8_hold bank: capture when hold is 0, keep otherwise.
    logic [N-1:0] bank [NREG];
    always @(posedge clk) begin
        for (int k = 0; k < NREG; k++) begin
            if (!reg_hold[k]) bank[k] <= reg_din;
        end
    end

    npu_hold_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .cfg_len_i (cfg_len_i),
        .abort_i   (abort_i),
        .release_i (release_i),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reg_din   (reg_din),
        .reg_hold  (reg_hold),
        .busy      (busy),
        .locked    (locked),
        .done      (done),
        .load_idx  (load_idx)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    // Reference model: phase 0 idle, 1 loading, 2 locked.
    int         m_phase, m_len, m_idx, m_zero, m_done;
    logic [7:0] m_din;
    logic [7:0] m_bank [NREG];
    bit         m_known [NREG];
    int         p_idx;
    logic [7:0] p_data;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit s, input int len, input bit ab,
                             input bit rel, input bit v, input int data);
        if (p_idx >= 0) begin
            m_bank[p_idx]  = p_data;
            m_known[p_idx] = 1'b1;
        end
        p_idx  = -1;
        m_done = 0;
        m_zero = -1;
        if (r) begin
            m_phase = 0;
            m_idx   = 0;
            m_din   = 8'h00;
            return;
        end
        case (m_phase)
            0: if (s) begin
                m_len   = (len == 0 || len > NREG) ? NREG : len;
                m_idx   = 0;
                m_phase = 1;
            end
            1: begin
                if (v) begin
                    m_din  = data[7:0];
                    m_zero = m_idx;
                    p_idx  = m_idx;
                    p_data = data[7:0];
                    m_idx++;
                end
                if (ab) begin
                    m_phase = 0;
                    m_idx   = 0;
                end else if (v && m_idx == m_len) begin
                    m_phase = 2;
                    m_done  = 1;
                end
            end
            default: if (rel) begin
                m_phase = 0;
                m_idx   = 0;
            end
        endcase
    endtask

    task automatic compareOutputs();
        logic [NREG-1:0] eh;
        eh = '1;
        if (m_zero >= 0) eh[m_zero] = 1'b0;
        if (done === 1'b1) done_seen++;
        checkOutput("in_ready", in_ready, m_phase == 1);
        checkOutput("busy", busy, m_phase != 0);
        checkOutput("locked", locked, m_phase == 2);
        checkOutput("done", done, m_done);
        checkOutput("load_idx", load_idx, m_idx);
        checkOutput("reg_din", reg_din, m_din);
        checkOutput("reg_hold", reg_hold, eh);
        for (int k = 0; k < NREG; k++) begin
            if (m_known[k]) checkOutput($sformatf("bank%0d", k), bank[k], m_bank[k]);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input int len, input bit ab,
                                 input bit rel, input bit v, input int data);
        @(negedge clk);
        rst       = r;
        start_i   = s;
        cfg_len_i = IDX_W'(len);
        abort_i   = ab;
        release_i = rel;
        in_valid  = v;
        in_data   = N'(data);
        modelStep(r, s, len, ab, rel, v, data);
        @(posedge clk);
        #1;
        compareOutputs();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic loadBytes(input int len, input int b0, input int b1, input int b2, input int b3);
        int bytes [4];
        bytes = '{b0, b1, b2, b3};
        applyStimulus(0, 1, len, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1, bytes[i]);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; cfg_len_i = '0; abort_i = 1'b0;
        release_i = 1'b0; in_valid = 1'b0; in_data = '0;
        m_phase = 0; m_len = NREG; m_idx = 0; m_zero = -1; m_done = 0;
        m_din = 8'h00; p_idx = -1; p_data = 8'h00;
        for (int k = 0; k < NREG; k++) begin
            m_bank[k]  = 8'h00;
            m_known[k] = 1'b0;
        end

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // Full back-to-back load of four bytes.
        done_seen = 0;
        loadBytes(4, 128, 56, 43, 27);
        idle(2);
        checkOutput("done_count", done_seen, 1);
        checkOutput("r0_signed", 32'($signed(bank[0])), 32'(-128));
        checkOutput("r1_signed", 32'($signed(bank[1])), 32'(56));
        checkOutput("r2_signed", 32'($signed(bank[2])), 32'(43));
        checkOutput("r3_signed", 32'($signed(bank[3])), 32'(27));
        checkOutput("locked_hold", locked, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);

        // Two-register load with a gappy stream.
        applyStimulus(0, 1, 2, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, (i % 2) == 1, 90 + i);
        idle(1);
        checkOutput("r2_kept", bank[2], 8'd43);
        checkOutput("r3_kept", bank[3], 8'd27);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);

        // Zero and oversized lengths both load the whole bank.
        loadBytes(0, 1, 2, 3, 4);
        checkOutput("len0_idx", load_idx, 4);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        loadBytes(7, 5, 6, 7, 8);
        checkOutput("len7_lock", locked, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);

        // Abort after two bytes, then abort coinciding with a handshake.
        applyStimulus(0, 1, 4, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 230);
        applyStimulus(0, 0, 0, 0, 0, 1, 75);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        idle(1);
        checkOutput("abort_r0", 32'($signed(bank[0])), 32'(-26));
        checkOutput("abort_r1", 32'($signed(bank[1])), 32'(75));
        applyStimulus(0, 1, 4, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 99);
        idle(2);

        // LOCKED ignores start and stream bytes; start with release only releases.
        applyStimulus(0, 1, 2, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 11);
        applyStimulus(0, 0, 0, 0, 0, 1, 22);
        applyStimulus(0, 1, 3, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 33);
        applyStimulus(0, 1, 3, 0, 1, 1, 44);
        idle(2);

        // Reset in the middle of a load.
        applyStimulus(0, 1, 4, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 55);
        applyStimulus(1, 0, 0, 0, 0, 1, 66);
        idle(1);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 77);
        idle(1);
        checkOutput("rst_r0", bank[0], 8'd77);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom % 97) == 0, ($urandom % 4) == 0, int'($urandom_range(0, 7)),
                          ($urandom % 16) == 0, ($urandom % 6) == 0, ($urandom % 3) != 0,
                          int'($urandom_range(0, 255)));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
